// File: rtl/fp_mul_round_status.sv
// Final two-stage FP32 multiplier pipeline: normalise and extract guard/sticky, then round,
// classify and pack the IEEE-754 single result with its status word (flush-to-zero).
module fp_mul_round_status (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic signed [9:0]  in_exp,
    input  logic [47:0]        in_mant,
    input  logic               in_zero,
    input  logic               in_inf,
    input  logic               in_nan,
    input  logic [2:0]         rnd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        z,
    output logic [7:0]         status
);

    logic               en;
    logic               s1_valid_q;
    logic               s1_sign_q, s1_zero_q, s1_inf_q, s1_nan_q, s1_g_q, s1_s_q;
    logic [2:0]         s1_rnd_q;
    logic [22:0]        s1_frac_q;
    logic signed [11:0] s1_exp_q;

    logic [22:0]        s1_frac_d;
    logic               s1_g_d, s1_s_d;
    logic signed [11:0] s1_exp_d;
    logic [2:0]         s1_rnd_d;

    logic               out_valid_q;
    logic [31:0]        z_q, z_d;
    logic [7:0]         status_q, status_d;

    function automatic logic round_inc(input logic [2:0] mode, input logic sign,
                                       input logic lsb, input logic g, input logic s);
        case (mode)
            3'd0:    round_inc = g & (s | lsb);
            3'd1:    round_inc = 1'b0;
            3'd2:    round_inc = ~sign & (g | s);
            3'd3:    round_inc = sign & (g | s);
            3'd4:    round_inc = g;
            3'd5:    round_inc = g | s;
            default: round_inc = g & (s | lsb);
        endcase
    endfunction

    assign en        = out_ready | ~out_valid_q;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign z         = z_q;
    assign status    = status_q;

    // Stage 1: normalise the product and split into fraction, guard and sticky
    always_comb begin
        s1_frac_d = in_mant[45:23];
        s1_g_d    = in_mant[22];
        s1_s_d    = |in_mant[21:0];
        s1_exp_d  = {{2{in_exp[9]}}, in_exp};
        if (in_mant[47]) begin
            s1_frac_d = in_mant[46:24];
            s1_g_d    = in_mant[23];
            s1_s_d    = |in_mant[22:0];
            s1_exp_d  = {{2{in_exp[9]}}, in_exp} + 12'sd1;
        end
        s1_rnd_d = (rnd > 3'd5) ? 3'd0 : rnd;
    end

    always_ff @(posedge clk) begin
        if (en) begin
            s1_sign_q <= in_sign;
            s1_zero_q <= in_zero;
            s1_inf_q  <= in_inf;
            s1_nan_q  <= in_nan;
            s1_rnd_q  <= s1_rnd_d;
            s1_frac_q <= s1_frac_d;
            s1_g_q    <= s1_g_d;
            s1_s_q    <= s1_s_d;
            s1_exp_q  <= s1_exp_d;
        end
    end

    // Stage 2: round, detect overflow/underflow, apply class priority and pack
    logic               inc, inexact, to_max, to_min;
    logic [23:0]        sum;
    logic signed [11:0] exp_r;

    always_comb begin
        inc     = round_inc(s1_rnd_q, s1_sign_q, s1_frac_q[0], s1_g_q, s1_s_q);
        sum     = {1'b0, s1_frac_q} + {23'd0, inc};
        exp_r   = s1_exp_q + (sum[23] ? 12'sd1 : 12'sd0);
        inexact = s1_g_q | s1_s_q;
        to_max  = (s1_rnd_q == 3'd1) | ((s1_rnd_q == 3'd2) & s1_sign_q)
                | ((s1_rnd_q == 3'd3) & ~s1_sign_q);
        to_min  = (s1_rnd_q == 3'd5) | ((s1_rnd_q == 3'd2) & ~s1_sign_q)
                | ((s1_rnd_q == 3'd3) & s1_sign_q);
        z_d      = {s1_sign_q, exp_r[7:0], sum[23] ? 23'd0 : sum[22:0]};
        status_d = {2'b00, inexact, 5'b00000};
        if (s1_nan_q | (s1_inf_q & s1_zero_q)) begin
            z_d      = 32'h7FC0_0000;
            status_d = 8'h04;
        end else if (s1_inf_q) begin
            z_d      = {s1_sign_q, 8'hFF, 23'd0};
            status_d = 8'h02;
        end else if (s1_zero_q) begin
            z_d      = {s1_sign_q, 31'd0};
            status_d = 8'h01;
        end else if (exp_r >= 12'sd255) begin
            z_d      = to_max ? {s1_sign_q, 31'h7F7F_FFFF} : {s1_sign_q, 8'hFF, 23'd0};
            status_d = 8'h30;
        end else if (exp_r <= 12'sd0) begin
            z_d      = to_min ? {s1_sign_q, 31'h0080_0000} : {s1_sign_q, 31'd0};
            status_d = 8'h28;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            z_q         <= 32'd0;
            status_q    <= 8'd0;
        end else if (en) begin
            s1_valid_q  <= in_valid;
            out_valid_q <= s1_valid_q;
            z_q         <= z_d;
            status_q    <= status_d;
        end
    end

endmodule
